// File: rtl/fac_pkg.sv
// rtl/fac_pkg.sv - shared states, ASCII constants and factorial helper for the factorial-base printer
package fac_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_DIGIT = 3'd2;
  localparam logic [2:0] S_EMIT  = 3'd3;
  localparam logic [2:0] S_DELIM = 3'd4;
  localparam logic [2:0] S_NEXT  = 3'd5;

  localparam logic [7:0] ASCII_CR = 8'd13;
  localparam logic [7:0] ASCII_LF = 8'd10;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;

  // Wide result; callers cast down to their own value width.
  function automatic logic [63:0] fact(input int unsigned k);
    logic [63:0] f;
    f = 64'd1;
    for (int unsigned i = 2; i <= k; i++) f = f * 64'(i);
    return f;
  endfunction

  function automatic logic [7:0] digit_ascii(input logic [7:0] d);
    return (d < 8'd10) ? (ASCII_0 + d) : (ASCII_A + (d - 8'd10));
  endfunction

endpackage

// File: rtl/fac_digit_gen.sv
// rtl/fac_digit_gen.sv - repeated-subtraction factorial-base digit generator, one position at a time
module fac_digit_gen
  import fac_pkg::*;
#(
  parameter int unsigned W      = 22,
  parameter int unsigned MAXPOS = 10,
  localparam int unsigned PW    = $clog2(MAXPOS + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         sub_en,
  input  logic         advance,
  input  logic [W-1:0] n_in,
  output logic [7:0]   digit,
  output logic         digit_final,
  output logic         emit_en,
  output logic         last_pos
);

  logic [W-1:0]  n_work;
  logic [W-1:0]  pos_fact;
  logic [PW-1:0] pos;
  logic          seen_nz;

  always_comb begin
    pos_fact = '0;
    for (int unsigned k = 0; k <= MAXPOS; k++)
      if (pos == PW'(k)) pos_fact = W'(fact(k));
  end

  assign digit_final = n_work < pos_fact;
  assign last_pos    = (pos == PW'(1));
  // Position 1 always prints so that a zero value still yields "0".
  assign emit_en     = (digit != 8'd0) | seen_nz | last_pos;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_work  <= '0;
      pos     <= '0;
      seen_nz <= 1'b0;
      digit   <= '0;
    end else if (load) begin
      n_work  <= n_in;
      pos     <= PW'(MAXPOS);
      seen_nz <= 1'b0;
      digit   <= '0;
    end else if (sub_en) begin
      n_work  <= n_work - pos_fact;
      digit   <= digit + 8'd1;
    end else if (advance) begin
      seen_nz <= emit_en;
      pos     <= pos - PW'(1);
      digit   <= '0;
    end
  end

endmodule

// File: rtl/fac_seq_printer.sv
// rtl/fac_seq_printer.sv - streams N_FIRST..N_LAST in factorial base over a byte handshake; DELIM_CRLF_EN selects CR/LF delimiter
module fac_seq_printer
  import fac_pkg::*;
#(
  parameter int unsigned W       = 22,
  parameter int unsigned MAXPOS  = 10,
  parameter int unsigned N_FIRST = 0,
  parameter int unsigned N_LAST  = 3628800,
  parameter int unsigned STEP    = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic [7:0]   out_byte,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] cur_n,
  output logic         busy,
  output logic [W-1:0] result,
  output logic         result_ready
);

  localparam int unsigned WX = W + 1;
  localparam logic [W:0]  LAST_X = WX'(N_LAST);
  localparam logic [W:0]  STEP_X = WX'(STEP);

  logic [2:0] state;
  logic [7:0] digit;
  logic       digit_final;
  logic       emit_en;
  logic       last_pos;
  logic       xfer;
  logic       advance;
  logic [W:0] next_x;
`ifdef DELIM_CRLF_EN
  logic       delim_idx;
`endif

  assign xfer    = out_valid & out_ready;
  assign advance = (state == S_EMIT) & ~start & (~emit_en | xfer);
  // One bit wider so the end-of-range test cannot wrap.
  assign next_x  = {1'b0, cur_n} + STEP_X;

  assign busy         = (state != S_IDLE);
  assign result_ready = (state == S_IDLE) & ~start;

  fac_digit_gen #(.W(W), .MAXPOS(MAXPOS)) u_digit (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (state == S_LOAD),
    .sub_en      ((state == S_DIGIT) & ~digit_final),
    .advance     (advance),
    .n_in        (cur_n),
    .digit       (digit),
    .digit_final (digit_final),
    .emit_en     (emit_en),
    .last_pos    (last_pos)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      out_byte  <= 8'd0;
      cur_n     <= '0;
      result    <= '0;
`ifdef DELIM_CRLF_EN
      delim_idx <= 1'b0;
`endif
    end else if (start) begin
      state     <= S_LOAD;
      cur_n     <= W'(N_FIRST);
      out_valid <= 1'b0;
`ifdef DELIM_CRLF_EN
      delim_idx <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: ;
        S_LOAD: state <= S_DIGIT;
        S_DIGIT: if (digit_final) state <= S_EMIT;
        S_EMIT: begin
          if (~emit_en | xfer) begin
            out_valid <= 1'b0;
            state     <= last_pos ? S_DELIM : S_DIGIT;
          end else if (~out_valid) begin
            out_valid <= 1'b1;
            out_byte  <= digit_ascii(digit);
          end
        end
        S_DELIM: begin
`ifdef DELIM_CRLF_EN
          if (~out_valid) begin
            out_valid <= 1'b1;
            out_byte  <= ASCII_CR;
            delim_idx <= 1'b0;
          end else if (out_ready) begin
            if (!delim_idx) begin
              out_byte  <= ASCII_LF;
              delim_idx <= 1'b1;
            end else begin
              out_valid <= 1'b0;
              state     <= S_NEXT;
            end
          end
`else
          if (~out_valid) begin
            out_valid <= 1'b1;
            out_byte  <= ASCII_SP;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_NEXT;
          end
`endif
        end
        S_NEXT: begin
          if (next_x > LAST_X) begin
            result <= cur_n;
            state  <= S_IDLE;
          end else begin
            cur_n <= next_x[W-1:0];
            state <= S_LOAD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
